mem_arbiter: RTL

Single-port memory controller and arbiter between instruction fetch (IF) and the MEM stage. It shares the byte-wide RAM port, and sequences 1/2/4-byte accesses as consecutive byte transfers, little-endian. It drives `stallreq_if` / `stallreq_mem` into the stall controller so the pipeline freezes while an access is outstanding. An IF access can be aborted by a branch flush.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline, the memory arbiter and the byte-wide RAM.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              stallreq_if;
  logic              stallreq_mem;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_size,
    input  mem_addr, mem_wdata, ram_din,
    output if_data, if_done,
    output mem_rdata, mem_done,
    output ram_addr, ram_wr, ram_dout,
    output stallreq_if, stallreq_mem
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_size,
    output mem_addr, mem_wdata, ram_din,
    input  if_data, if_done,
    input  mem_rdata, mem_done,
    input  ram_addr, ram_wr, ram_dout,
    input  stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter for IF and MEM, little-endian 1/2/4-byte access.
// Optional round-robin arbitration: define MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        c;
  logic [2:0]        n;
  logic [ADDR_W-1:0] base;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;

  logic              if_ok;
  logic              grant_mem;
  logic              grant_if;
  logic [2:0]        mem_n;
  logic [2:0]        c_inc;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        wbyte_next;
  logic [31:0]       captured;

`ifdef MEM_ARB_FAIR_EN
  logic              last_mem;
`endif

  assign if_ok = bus.if_req & ~bus.if_flush;

`ifdef MEM_ARB_FAIR_EN
  assign grant_mem = bus.mem_req & (~if_ok | ~last_mem);
`else
  assign grant_mem = bus.mem_req;
`endif
  assign grant_if = if_ok & ~grant_mem;

  assign c_inc      = c + 3'd1;
  assign next_addr  = base + ADDR_W'(c_inc);
  assign wbyte_next = wdata_q[{c_inc[1:0], 3'b000} +: 8];

  assign bus.stallreq_if  = bus.if_req & ~bus.if_done;
  assign bus.stallreq_mem = bus.mem_req & ~bus.mem_done;

  // Transfer length for the MEM request size
  always_comb begin
    mem_n = 3'd4;
    unique case (1'b1)
      (bus.mem_size == 2'b00): mem_n = 3'd1;
      (bus.mem_size == 2'b01): mem_n = 3'd2;
      default:                 mem_n = 3'd4;
    endcase
  end

  // Merge the byte returned for address base+c-1 into its lane
  always_comb begin
    captured = buf_q;
    case (c)
      3'd1:    captured[7:0]   = bus.ram_din;
      3'd2:    captured[15:8]  = bus.ram_din;
      3'd3:    captured[23:16] = bus.ram_din;
      3'd4:    captured[31:24] = bus.ram_din;
      default: captured = buf_q;
    endcase
  end

  // Arbitration FSM, byte sequencing and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      c             <= 3'd0;
      n             <= 3'd0;
      base          <= '0;
      we_q          <= 1'b0;
      wdata_q       <= 32'd0;
      buf_q         <= 32'd0;
      bus.ram_addr  <= '0;
      bus.ram_wr    <= 1'b0;
      bus.ram_dout  <= 8'd0;
      bus.if_data   <= 32'd0;
      bus.if_done   <= 1'b0;
      bus.mem_rdata <= 32'd0;
      bus.mem_done  <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_mem      <= 1'b0;
`endif
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      case (state)
        IDLE: begin
          bus.ram_wr <= 1'b0;
          c          <= 3'd0;
          buf_q      <= 32'd0;
          if (grant_mem) begin
            state        <= MEM_BUSY;
            n            <= mem_n;
            base         <= bus.mem_addr;
            we_q         <= bus.mem_we;
            wdata_q      <= bus.mem_wdata;
            bus.ram_addr <= bus.mem_addr;
            bus.ram_wr   <= bus.mem_we;
            bus.ram_dout <= bus.mem_wdata[7:0];
`ifdef MEM_ARB_FAIR_EN
            last_mem     <= 1'b1;
`endif
          end else if (grant_if) begin
            state        <= IF_BUSY;
            n            <= 3'd4;
            base         <= bus.if_addr;
            we_q         <= 1'b0;
            bus.ram_addr <= bus.if_addr;
`ifdef MEM_ARB_FAIR_EN
            last_mem     <= 1'b0;
`endif
          end
        end
        IF_BUSY: begin
          if (bus.if_flush) begin
            state <= IDLE;
            c     <= 3'd0;
            buf_q <= 32'd0;
          end else begin
            buf_q <= captured;
            if (c == n) begin
              state       <= DONE;
              bus.if_done <= 1'b1;
              bus.if_data <= captured;
            end else begin
              c            <= c_inc;
              bus.ram_addr <= next_addr;
            end
          end
        end
        MEM_BUSY: begin
          if (we_q) begin
            if (c == n - 3'd1) begin
              state         <= DONE;
              bus.ram_wr    <= 1'b0;
              bus.mem_done  <= 1'b1;
              bus.mem_rdata <= 32'd0;
            end else begin
              c            <= c_inc;
              bus.ram_addr <= next_addr;
              bus.ram_dout <= wbyte_next;
            end
          end else begin
            buf_q <= captured;
            if (c == n) begin
              state         <= DONE;
              bus.mem_done  <= 1'b1;
              bus.mem_rdata <= captured;
            end else begin
              c            <= c_inc;
              bus.ram_addr <= next_addr;
            end
          end
        end
        default: begin
          state         <= IDLE;
          c             <= 3'd0;
          bus.ram_wr    <= 1'b0;
          bus.if_data   <= 32'd0;
          bus.mem_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
